// File: rtl/nv_nvdla_slcg_pkg.sv
// Shared definitions for the multi-channel SLCG controller.
package nv_nvdla_slcg_pkg;

    // Default width of the hold-off counter
    localparam int SLCG_HOLD_W_DEF = 8;

    // Per-channel gating state
    typedef enum logic [1:0] {
        ST_GATED = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2
    } slcg_state_e;

endpackage

// File: rtl/NV_CLK_gate_power.sv
// Behavioural latch-based clock gate cell: the enable is captured while the
// clock is low, so the gated clock never produces a truncated high pulse.
module NV_CLK_gate_power (
    input  logic clk,
    input  logic reset_,
    input  logic clk_en,
    output logic clk_gated
);

    logic r_en_lat;

    // Transparent-low enable latch; reset forces the gate closed
    always_latch begin
        if (!clk) begin
            r_en_lat = clk_en & reset_;
        end
    end

    assign clk_gated = clk & r_en_lat;

endmodule

// File: rtl/nv_nvdla_slcg_chan.sv
// One SLCG channel: GATED/RUN/HOLD state machine, hold-off down-counter and
// the registered clock enable for that channel's gate cell.
module nv_nvdla_slcg_chan
    import nv_nvdla_slcg_pkg::*;
#(
    parameter int HOLD_W = SLCG_HOLD_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req,
    input  logic              i_force,
    input  logic [HOLD_W-1:0] i_hold_cycles,
    output logic              o_clk_en,
    output logic              o_hold
);

    slcg_state_e       r_state;
    slcg_state_e       w_nxt_state;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_nxt_cnt;
    logic              r_clk_en;
    logic              r_hold;

    // Next-state and counter update; hold length is captured only on RUN->HOLD
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            ST_GATED: begin
                if (i_req) begin
                    w_nxt_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_req) begin
                    if (i_hold_cycles == '0) begin
                        w_nxt_state = ST_GATED;
                    end else begin
                        w_nxt_state = ST_HOLD;
                        w_nxt_cnt   = i_hold_cycles;
                    end
                end
            end
            ST_HOLD: begin
                if (i_req) begin
                    w_nxt_state = ST_RUN;
                    w_nxt_cnt   = '0;
                end else if (r_cnt <= HOLD_W'(1)) begin
                    // cnt==0 cannot occur in HOLD; treat it as expiry so the
                    // counter can never wrap
                    w_nxt_state = ST_GATED;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt - HOLD_W'(1);
                end
            end
            default: begin
                w_nxt_state = ST_GATED;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // State, counter and enable registers; reset dominates req and force
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state  <= ST_GATED;
            r_cnt    <= '0;
            r_clk_en <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_clk_en <= (w_nxt_state != ST_GATED) | i_force;
            r_hold   <= (w_nxt_state == ST_HOLD);
        end
    end

    assign o_clk_en = r_clk_en;
    assign o_hold   = r_hold;

endmodule

// File: rtl/nv_nvdla_slcg_mc.sv
// Multi-channel second-level clock-gating controller. Combines the per-channel
// enable sources and the override inputs, runs one gating FSM per channel and
// drives one gate cell per output clock.
module nv_nvdla_slcg_mc
    import nv_nvdla_slcg_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int NUM_SRC = 2,
    parameter int HOLD_W  = SLCG_HOLD_W_DEF
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic                      dla_clk_ovr_on_sync,
    input  logic                      global_clk_ovr_on_sync,
    input  logic                      tmc2slcg_disable_clock_gating,
    input  logic [NUM_CH*NUM_SRC-1:0] slcg_en_src,
    input  logic [HOLD_W-1:0]         cfg_hold_cycles,
    output logic [NUM_CH-1:0]         slcg_clk_en,
    output logic [NUM_CH-1:0]         slcg_ch_hold,
    output logic [NUM_CH-1:0]         nvdla_core_gated_clk
);

    logic [NUM_CH-1:0] w_req;
    logic              w_force;

    // Any override keeps every clock running without disturbing FSM state
    assign w_force = dla_clk_ovr_on_sync | global_clk_ovr_on_sync |
                     tmc2slcg_disable_clock_gating;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // A channel demands its clock only when all of its sources agree
        assign w_req[c] = &slcg_en_src[c*NUM_SRC +: NUM_SRC];

        nv_nvdla_slcg_chan #(
            .HOLD_W (HOLD_W)
        ) u_chan (
            .i_clk         (nvdla_core_clk),
            .i_rstn        (nvdla_core_rstn),
            .i_req         (w_req[c]),
            .i_force       (w_force),
            .i_hold_cycles (cfg_hold_cycles),
            .o_clk_en      (slcg_clk_en[c]),
            .o_hold        (slcg_ch_hold[c])
        );

        NV_CLK_gate_power u_gate (
            .clk       (nvdla_core_clk),
            .reset_    (nvdla_core_rstn),
            .clk_en    (slcg_clk_en[c]),
            .clk_gated (nvdla_core_gated_clk[c])
        );
    end

endmodule

// File: tb/tb_nv_nvdla_slcg_mc.sv
// Testbench for nv_nvdla_slcg_mc: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a cycle-stamp reference model.
module tb_nv_nvdla_slcg_mc;

    localparam int NUM_CH  = 4;
    localparam int NUM_SRC = 3;
    localparam int HOLD_W  = 8;

    logic                      clk;
    logic                      rstn;
    logic                      dla_ovr;
    logic                      glb_ovr;
    logic                      tmc_dis;
    logic [NUM_CH*NUM_SRC-1:0] src;
    logic [HOLD_W-1:0]         cfg;
    logic [NUM_CH-1:0]         clk_en;
    logic [NUM_CH-1:0]         ch_hold;
    logic [NUM_CH-1:0]         gclk;

    int n_tests;
    int n_fail;

    // Reference model state: cycle stamp of the last edge that saw req=1 and
    // the hold length captured on the first low edge after it.
    int cyc;
    int last_hi  [NUM_CH];
    int hold_len [NUM_CH];
    logic [NUM_CH-1:0] prev_en;

    logic [2*NUM_CH-1:0] sb_q[$];

    nv_nvdla_slcg_mc #(
        .NUM_CH  (NUM_CH),
        .NUM_SRC (NUM_SRC),
        .HOLD_W  (HOLD_W)
    ) dut (
        .nvdla_core_clk                (clk),
        .nvdla_core_rstn               (rstn),
        .dla_clk_ovr_on_sync           (dla_ovr),
        .global_clk_ovr_on_sync        (glb_ovr),
        .tmc2slcg_disable_clock_gating (tmc_dis),
        .slcg_en_src                   (src),
        .cfg_hold_cycles               (cfg),
        .slcg_clk_en                   (clk_en),
        .slcg_ch_hold                  (ch_hold),
        .nvdla_core_gated_clk          (gclk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: evaluate the model on the inputs the DUT sees, queue the
    // expected outputs, then check the gated clock during the high phase.
    task automatic step();
        logic [NUM_CH-1:0] e_en;
        logic [NUM_CH-1:0] e_hold;
        logic              frc;
        logic              req;
        logic              in_hold;
        logic [NUM_CH-1:0] e_gclk;
        @(posedge clk);
        e_gclk = prev_en & {NUM_CH{rstn}};
        frc = dla_ovr | glb_ovr | tmc_dis;
        for (int c = 0; c < NUM_CH; c++) begin
            req = &src[c*NUM_SRC +: NUM_SRC];
            if (!rstn) begin
                last_hi[c] = -1;
                e_en[c]    = 1'b0;
                e_hold[c]  = 1'b0;
            end else begin
                if (req) begin
                    last_hi[c] = cyc;
                end else if (last_hi[c] >= 0 && cyc - last_hi[c] == 1) begin
                    hold_len[c] = int'(cfg);
                end
                in_hold = !req && last_hi[c] >= 0 &&
                          (cyc - last_hi[c]) <= hold_len[c];
                e_hold[c] = in_hold;
                e_en[c]   = req | in_hold | frc;
            end
        end
        sb_q.push_back({e_en, e_hold});
        cyc++;
        #1;
        n_tests++;
        if (gclk !== e_gclk) begin
            n_fail++;
            $display("FAIL gated_clk: got %b expected %b (t=%0t)", gclk, e_gclk, $time);
        end
        prev_en = e_en;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: registered outputs are stable in the low phase; pop and compare
    initial begin
        logic [2*NUM_CH-1:0] e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (clk_en !== e[2*NUM_CH-1:NUM_CH]) begin
                    n_fail++;
                    $display("FAIL clk_en: got %b expected %b (t=%0t)",
                             clk_en, e[2*NUM_CH-1:NUM_CH], $time);
                end
                n_tests++;
                if (ch_hold !== e[NUM_CH-1:0]) begin
                    n_fail++;
                    $display("FAIL ch_hold: got %b expected %b (t=%0t)",
                             ch_hold, e[NUM_CH-1:0], $time);
                end
            end
        end
    end

    // Watchdog bounds the whole run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        prev_en = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            last_hi[c]  = -1;
            hold_len[c] = 0;
        end

        // Reset with every request and an override active
        rstn    = 1'b0;
        dla_ovr = 1'b1;
        glb_ovr = 1'b0;
        tmc_dis = 1'b0;
        src     = '1;
        cfg     = 8'd4;
        #1;
        steps(3);
        rstn = 1'b1;
        steps(1);
        dla_ovr = 1'b0;
        src     = '0;
        steps(8);

        // Hold-off of 4 on channel 0
        cfg = 8'd4;
        src[2:0] = 3'b111;
        steps(10);
        src[2:0] = 3'b110;
        steps(8);

        // Zero hold drops the enable on the next edge
        cfg = 8'd0;
        src[2:0] = 3'b111;
        steps(3);
        src[2:0] = 3'b000;
        steps(3);

        // Re-arm inside HOLD, then a fresh 8-cycle hold
        cfg = 8'd8;
        src[2:0] = 3'b111;
        steps(3);
        src[2:0] = 3'b000;
        steps(3);
        src[2:0] = 3'b111;
        steps(1);
        src[2:0] = 3'b000;
        steps(12);

        // Each override input alone, with no requests
        for (int k = 0; k < 3; k++) begin
            dla_ovr = (k == 0);
            glb_ovr = (k == 1);
            tmc_dis = (k == 2);
            steps(5);
            dla_ovr = 1'b0;
            glb_ovr = 1'b0;
            tmc_dis = 1'b0;
            steps(3);
        end

        // Independence: only ch2 has all sources, ch1 is one short
        src = 12'b000_111_110_000;
        steps(4);
        src = '0;
        steps(3);

        // Maximum hold on ch3; a cfg change mid-hold must be ignored
        cfg = 8'd255;
        src[11:9] = 3'b111;
        steps(2);
        src[11:9] = 3'b000;
        steps(20);
        cfg = 8'd3;
        steps(240);

        // Reset asserted in the middle of HOLD
        cfg = 8'd20;
        src = '1;
        steps(2);
        src = '0;
        steps(3);
        rstn = 1'b0;
        steps(1);
        rstn = 1'b1;
        steps(3);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    src[c*NUM_SRC +: NUM_SRC] = ($urandom_range(0, 1) == 1) ?
                        3'b111 : NUM_SRC'($urandom_range(0, 7));
                end
            end
            if ($urandom_range(0, 15) == 0) cfg = HOLD_W'($urandom_range(0, 6));
            dla_ovr = ($urandom_range(0, 19) == 0);
            glb_ovr = ($urandom_range(0, 19) == 0);
            tmc_dis = ($urandom_range(0, 19) == 0);
            rstn    = ($urandom_range(0, 49) != 0);
            step();
        end
        rstn    = 1'b1;
        dla_ovr = 1'b0;
        glb_ovr = 1'b0;
        tmc_dis = 1'b0;
        src     = '0;
        steps(10);

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
